// File: rtl/bitnet_pkg.sv
// Shared constants and types for the BitNet datapath.
//   ACT_W / ACT_MIN / ACT_MAX : signed activation format
//   TREE_SUM_W                : width of the tree-adder chunk sum
//   acc_state_t               : accumulate/requantize sequencer states
package bitnet_pkg;

  localparam int unsigned ACT_W      = 8;
  localparam int          ACT_MIN    = -128;
  localparam int          ACT_MAX    = 127;
  localparam int unsigned TREE_SUM_W = 20;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    SCALE = 2'd1,
    ROUND = 2'd2,
    OUT   = 2'd3
  } acc_state_t;

endpackage

// File: rtl/requant_round_sat.sv
// Combinational round-half-up arithmetic shift and saturation to the
// signed activation range.
//   i_prod    : signed scaled accumulator
//   i_shift   : right-shift amount 0..31
//   o_act_c   : saturated signed activation
//   o_sat_c   : result was clipped
module requant_round_sat
  import bitnet_pkg::*;
#(
  parameter int unsigned PROD_W = 49
) (
  input  logic signed [PROD_W-1:0] i_prod,
  input  logic        [4:0]        i_shift,
  output logic signed [ACT_W-1:0]  o_act_c,
  output logic                     o_sat_c
);

  // One guard bit so adding the rounding term can never wrap.
  localparam int unsigned RW = PROD_W + 1;
  localparam logic signed [RW-1:0] L_MAX = RW'(ACT_MAX);
  localparam logic signed [RW-1:0] L_MIN = RW'(ACT_MIN);

  logic signed [RW-1:0] w_ext;
  logic signed [RW-1:0] w_bias;
  logic signed [RW-1:0] w_sum;
  logic signed [RW-1:0] w_r;

  // Round half up, arithmetic shift, then clip.
  always_comb begin
    w_ext  = {i_prod[PROD_W-1], i_prod};
    w_bias = '0;
    if (i_shift != 5'd0) begin
      w_bias = RW'(1) << (i_shift - 5'd1);
    end
    w_sum   = w_ext + w_bias;
    w_r     = w_sum >>> i_shift;
    o_act_c = w_r[ACT_W-1:0];
    o_sat_c = 1'b0;
    if (w_r > L_MAX) begin
      o_act_c = ACT_W'(ACT_MAX);
      o_sat_c = 1'b1;
    end else if (w_r < L_MIN) begin
      o_act_c = ACT_W'(ACT_MIN);
      o_sat_c = 1'b1;
    end
  end

endmodule

// File: rtl/acc_requant.sv
// Accumulates chunk sums of one neuron, then scales, rounds and saturates
// to a signed 8-bit activation offered on a valid/ready output.
//   in_valid/in_ready/in_sum/in_last : chunk-sum input stream
//   scale/shift                      : requant params, taken on the last beat
//   out_valid/out_ready/out_act/out_sat : activation output handshake
//   seq_err                          : sticky beat-count overrun flag
module acc_requant
  import bitnet_pkg::*;
#(
  parameter int unsigned IN_W    = TREE_SUM_W,
  parameter int unsigned ACC_W   = 32,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned SCALE_W = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [IN_W-1:0]    in_sum,
  input  logic                      in_last,
  input  logic        [SCALE_W-1:0] scale,
  input  logic        [4:0]         shift,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [ACT_W-1:0]   out_act,
  output logic                      out_sat,
  output logic                      seq_err
);

  localparam int unsigned PROD_W = ACC_W + SCALE_W + 1;

  acc_state_t                r_state;
  acc_state_t                w_state_nxt;
  logic        [CNT_W-1:0]   r_cnt;
  logic signed [ACC_W-1:0]   r_acc;
  logic        [SCALE_W-1:0] r_scale;
  logic        [4:0]         r_shift;
  logic signed [PROD_W-1:0]  r_prod;
  logic                      r_in_ready;
  logic                      r_out_valid;
  logic signed [ACT_W-1:0]   r_out_act;
  logic                      r_out_sat;
  logic                      r_seq_err;

  logic                      w_accept;
  logic                      w_cnt_full;
  logic                      w_close;
  logic signed [ACC_W-1:0]   w_sum_ext;
  logic signed [ACT_W-1:0]   w_act;
  logic                      w_sat;

  assign w_accept   = in_valid & r_in_ready;
  assign w_cnt_full = (r_cnt == {CNT_W{1'b1}});
  // A full beat count forces the neuron closed even without in_last.
  assign w_close    = w_accept & (in_last | w_cnt_full);
  assign w_sum_ext  = {{(ACC_W - IN_W){in_sum[IN_W-1]}}, in_sum};

  requant_round_sat #(
    .PROD_W (PROD_W)
  ) u_round (
    .i_prod  (r_prod),
    .i_shift (r_shift),
    .o_act_c (w_act),
    .o_sat_c (w_sat)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ACCUM:   if (w_close) w_state_nxt = SCALE;
      SCALE:   w_state_nxt = ROUND;
      ROUND:   w_state_nxt = OUT;
      OUT:     if (out_ready) w_state_nxt = ACCUM;
      default: w_state_nxt = ACCUM;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_acc       <= '0;
      r_scale     <= '0;
      r_shift     <= '0;
      r_prod      <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_act   <= '0;
      r_out_sat   <= 1'b0;
      r_seq_err   <= 1'b0;
    end else begin
      r_in_ready <= (w_state_nxt == ACCUM);
      case (r_state)
        ACCUM: begin
          if (w_accept) begin
            r_acc <= (r_cnt == '0) ? w_sum_ext : r_acc + w_sum_ext;
            r_cnt <= r_cnt + CNT_W'(1);
          end
          if (w_close) begin
            r_scale <= scale;
            r_shift <= shift;
            if (!in_last) r_seq_err <= 1'b1;
          end
        end
        SCALE: begin
          r_prod <= r_acc * $signed({1'b0, r_scale});
        end
        ROUND: begin
          r_out_act   <= w_act;
          r_out_sat   <= w_sat;
          r_out_valid <= 1'b1;
        end
        OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_cnt       <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_act   = r_out_act;
  assign out_sat   = r_out_sat;
  assign seq_err   = r_seq_err;

endmodule

// File: doc/acc_requant.md
# acc_requant

Downstream stage of the tree adder. Accumulates a sequence of 20-bit signed tree sums (one per 4096-element chunk of a dot product) into one neuron pre-activation, then requantizes it to a signed 8-bit activation with a per-layer scale, round-half-up shift and saturation. The result is offered on a valid/ready output handshake. The layer controller drives `in_valid` through a 12-cycle delay line matched to the tree adder latency.

## Interface
- `IN_W`, 20: width of the incoming tree sum (signed).
- `ACC_W`, 32: accumulator width (signed).
- `CNT_W`, 8: beat-counter width; at most 2^CNT_W chunks per neuron.
- `SCALE_W`, 16: unsigned scale width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  `in_sum` is valid this cycle.
- `in_ready`  out  1  block accepts a beat.
- `in_sum`  in  IN_W  signed chunk sum from the tree adder.
- `in_last`  in  1  final chunk of the current neuron.
- `scale`  in  SCALE_W  unsigned multiplier; sampled on the accepted `in_last` beat.
- `shift`  in  5  right-shift amount (0..31); sampled with `scale`.
- `out_valid`  out  1  `out_act` is valid.
- `out_ready`  in  1  consumer accepts the output.
- `out_act`  out  8  signed requantized activation.
- `out_sat`  out  1  `out_act` was clipped; qualified by `out_valid`.
- `seq_err`  out  1  sticky flag: a neuron exceeded 2^CNT_W beats. Cleared only by reset.

## Operation
- FSM states: ACCUM, SCALE, ROUND, OUT. Reset state is ACCUM.
- **ACCUM**
  - `in_ready`=1. A beat is accepted when `in_valid`&`in_ready`.
  - First beat of a neuron (beat count 0): acc = sign-extended `in_sum`. Later beats: acc += sign-extended `in_sum`.
  - The beat count increments on every accepted beat.
  - An accepted beat with `in_last`=1 latches `scale` and `shift` and moves the FSM to SCALE.
  - If the beat count reaches 2^CNT_W−1 and another beat is accepted without `in_last`, that beat is treated as last and `seq_err` is set.
- **SCALE**
  - `in_ready`=0.
  - prod = acc × {0,scale}, signed, width ACC_W+SCALE_W+1, registered.
  - Next state: ROUND.
- **ROUND**
  - If shift>0: r = (prod + 2^(shift−1)) >>> shift. If shift=0: r = prod.
  - Saturate r to [−128, 127]. `out_sat` = 1 when clipping occurred.
  - Register the result into `out_act` and `out_sat`, set `out_valid`=1, go to OUT.
- **OUT**
  - Hold `out_act`, `out_sat` and `out_valid` stable until `out_ready`.
  - On `out_valid`&`out_ready`: clear `out_valid`, reset the beat count, go to ACCUM.
- Accumulator overflow cannot occur within 2^CNT_W beats (2^27 < 2^31). No wrap handling is required.
- Reset mid-operation: FSM returns to ACCUM; acc, beat count and any partial neuron are discarded.

## Timing
- Reset values: `in_ready`=0 while `rst_n`=0, and 1 from the first edge after release. `out_valid`=0, `out_act`=0, `out_sat`=0, `seq_err`=0.
- Latency: with the last beat accepted at edge E0, the product is registered at E1 and `out_valid` is high after E2 (2 cycles).
- `in_ready` is low from the edge after the last-beat acceptance until the cycle after the output handshake completes. Throughput is one neuron per (N beats + 3 cycles) when `out_ready`=1.
- `in_valid` during SCALE, ROUND or OUT is not accepted. The upstream must hold the beat; beats are never lost.
- `out_valid` must not drop and `out_act` must not change without a handshake.

## Structure
- Shared package `bitnet_pkg`:
  - constants `ACT_W`=8, `ACT_MIN`=−128, `ACT_MAX`=127, `TREE_SUM_W`=20;
  - FSM state enum `acc_state_t`.
- Sub-module `requant_round_sat`: combinational round, shift and saturate from prod/shift to act/sat, registered in the parent's ROUND state.

## Test plan
- Beats 1000, −200, 50 (last); scale=1, shift=4 → `out_act`=53, `out_sat`=0, `out_valid` 2 cycles after the last accept.
- Same beats with scale=3, shift=4 → (2550+8)>>>4=159 → `out_act`=127, `out_sat`=1. Repeat with beats negated → `out_act`=−128, `out_sat`=1.
- Single beat −100 (last), scale=1, shift=3 → `out_act`=−12. With shift=0 and scale=1, beat 7 → `out_act`=7, with no rounding term.
- Hold `out_ready`=0 for 5 cycles while `in_valid`=1 → `out_act` stable, `in_ready`=0, no beat consumed. Raise `out_ready` → the next neuron starts with acc = first new beat, with no leftover from the previous neuron.
- 256 beats of value 1 without `in_last` → the 256th beat closes the neuron and `seq_err`=1; scale=1, shift=0 → `out_act`=127, `out_sat`=1.
- Assert `rst_n`=0 during ROUND → `out_valid`=0 immediately. After release, beats 5 (last), scale=1, shift=0 → `out_act`=5.
